// File: rtl/seq_mag_comp.sv
// rtl/seq_mag_comp.sv - multi-cycle MSB-first magnitude comparator, early exit on first differing digit
module seq_mag_comp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NDIG - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              sgn_r;
    logic [IDXW-1:0]   idx;
    logic [DIGIT-1:0]  flip;
    logic [DIGIT-1:0]  dig_a;
    logic [DIGIT-1:0]  dig_b;
    logic              dig_gt;
    logic              dig_lt;
    logic              last;

    // Signed mode: flipping the sign bit of the top digit turns two's complement into offset binary
    always_comb begin
        flip            = '0;
        flip[DIGIT-1]   = sgn_r && (idx == TOP_IDX);
        dig_a           = a_r[idx*DIGIT +: DIGIT] ^ flip;
        dig_b           = b_r[idx*DIGIT +: DIGIT] ^ flip;
        dig_gt          = dig_a > dig_b;
        dig_lt          = dig_a < dig_b;
        last            = (idx == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (dig_gt || dig_lt || last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            sgn_r <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sgn_r <= sgn;
                        idx   <= TOP_IDX;
                        gt    <= 1'b0;
                        eq    <= 1'b0;
                        lt    <= 1'b0;
                    end
                end
                RUN: begin
                    if (dig_gt) begin
                        gt   <= 1'b1;
                        done <= 1'b1;
                    end else if (dig_lt) begin
                        lt   <= 1'b1;
                        done <= 1'b1;
                    end else if (last) begin
                        eq   <= 1'b1;
                        done <= 1'b1;
                    end else begin
                        idx  <= idx - IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comp.sv
// tb/tb_seq_mag_comp.sv - scoreboard bench for seq_mag_comp at DIGIT = 1, 4 and 16
module tb_seq_mag_comp;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic        sgn_v   [3];
    logic [15:0] a_v     [3];
    logic [15:0] b_v     [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        gt_v    [3];
    logic        eq_v    [3];
    logic        lt_v    [3];

    int   digs [3] = '{1, 4, 16};
    exp_t sb [3][$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    seq_mag_comp #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sgn(sgn_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]));
    seq_mag_comp #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sgn(sgn_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]));
    seq_mag_comp #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sgn(sgn_v[2]), .a(a_v[2]), .b(b_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] res_of(input int k);
        return {gt_v[k], eq_v[k], lt_v[k]};
    endfunction

    // Reference: full-width compare; latency from the highest digit where the operands differ
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  input int d, output logic [2:0] res, output int lat);
        logic [15:0] x;
        logic [31:0] mask;
        int          nd;
        bit          found;
        if (s) res = {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
        else   res = {a > b, a == b, a < b};
        x     = a ^ b;
        mask  = (32'd1 << d) - 32'd1;
        nd    = 16 / d;
        lat   = nd + 1;
        found = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            if (!found && ((32'(x) >> (i * d)) & mask) != 0) begin
                lat   = nd - i + 1;
                found = 1;
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle with start low
    // unless the caller immediately issues the next op.
    task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input bit hold);
        exp_t e;
        exp_t got_e;
        int   cyc;
        int   busy_cnt;
        bit   seen;
        model(a, b, s, digs[k], e.res, e.lat);
        sb[k].push_back(e);
        a_v[k] = a; b_v[k] = b; sgn_v[k] = s; start_v[k] = 1'b1;
        @(negedge clk);
        if (hold) begin
            a_v[k] = ~a; b_v[k] = a; sgn_v[k] = ~s;
        end else begin
            start_v[k] = 1'b0;
        end
        chk("busy_after_start", busy_v[k], 1);
        chk("res_cleared", res_of(k), 0);
        cyc = 1; busy_cnt = 0; seen = 0;
        while (cyc <= 20 && !seen) begin
            if (done_v[k]) seen = 1;
            else begin
                if (busy_v[k]) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
        end
        start_v[k] = 1'b0;
        chk("done_seen", seen, 1);
        if (seen) begin
            got_e = sb[k].pop_front();
            chk("result", res_of(k), got_e.res);
            chk("latency", cyc, got_e.lat);
            chk("busy_cycles", busy_cnt, got_e.lat - 1);
            chk("busy_in_done", busy_v[k], 0);
        end else begin
            void'(sb[k].pop_front());
        end
    endtask

    initial begin
        int  seen_done;
        logic [15:0] ra, rb;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 0; sgn_v[k] = 0; a_v[k] = 0; b_v[k] = 0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", busy_v[k], 0);
            chk("rst_done", done_v[k], 0);
            chk("rst_res", res_of(k), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        do_op(1, 16'h1234, 16'h1234, 1'b0, 0); @(negedge clk);
        do_op(1, 16'h9000, 16'h1FFF, 1'b0, 0); @(negedge clk);
        do_op(1, 16'h9000, 16'h1FFF, 1'b1, 0); @(negedge clk);
        do_op(1, 16'h00A5, 16'h00A7, 1'b0, 0); @(negedge clk);
        do_op(1, 16'hFFFF, 16'h0000, 1'b1, 0); @(negedge clk);
        do_op(1, 16'hFFFF, 16'h0000, 1'b0, 0); @(negedge clk);
        do_op(1, 16'h8000, 16'h7FFF, 1'b1, 0); @(negedge clk);

        // start held high with junk operands while busy must be ignored
        do_op(1, 16'h5A00, 16'h5A01, 1'b0, 1);
        @(negedge clk);
        chk("hold_idle", busy_v[1], 0);
        chk("hold_result", res_of(1), 3'b001);
        repeat (3) @(negedge clk);
        chk("hold_result_late", res_of(1), 3'b001);

        // back-to-back: second start issued in the done cycle of the first
        do_op(1, 16'h9000, 16'h1FFF, 1'b0, 0);
        do_op(1, 16'h1234, 16'h1234, 1'b0, 0);
        @(negedge clk);

        // reset mid-operation
        a_v[1] = 16'h1234; b_v[1] = 16'h1234; sgn_v[1] = 0; start_v[1] = 1;
        @(negedge clk);
        start_v[1] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy_v[1], 0);
        chk("abort_res", res_of(1), 0);
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_v[1]) seen_done++;
            @(negedge clk);
        end
        chk("abort_no_done", seen_done, 0);
        do_op(1, 16'h0001, 16'h8001, 1'b1, 0); @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 30; n++) begin
                ra = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: rb = ra;
                    1: rb = ra ^ (16'd1 << $urandom_range(0, 15));
                    default: rb = 16'($urandom);
                endcase
                do_op(k, ra, rb, 1'($urandom_range(0, 1)), 0);
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
